// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : UART transmitter with a configurable frame (5-9 data bits, parity
//            none/even/odd, 1-2 stop bits) and a one-word holding register for
//            back-to-back frames. Define UART_TX_BREAK_EN to add the brk input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    input  logic                 clken,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_ready,
    output logic                 overrun
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [3:0] c_DATA_BITS = 4'(DATA_BITS);
    localparam logic       c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic       c_ODD       = (PARITY == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_tx_frame: illegal parameter combination");
    end

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;
    logic [3:0]           r_bitcnt;
    logic                 r_stopcnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_overrun;
    logic                 w_stop_done;
    logic                 w_idle_ok;
    logic                 w_load;
    logic                 w_brk_busy;

`ifdef UART_TX_BREAK_EN
    logic                 r_brk_on;
    logic                 r_brk_guard;
    // After a break, one full clken period of idle must pass before a start bit.
    assign w_idle_ok  = !brk && !r_brk_on && !r_brk_guard;
    assign w_brk_busy = r_brk_on || r_brk_guard;
`else
    assign w_idle_ok  = 1'b1;
    assign w_brk_busy = 1'b0;
`endif

    assign w_stop_done = (r_stopcnt == c_STOP_LAST);
    assign w_load      = clken && r_hold_valid &&
                         ((r_state == c_IDLE && w_idle_ok) ||
                          (r_state == c_STOP && w_stop_done));

    assign tx       = r_tx;
    assign overrun  = r_overrun;
    assign tx_ready = !r_hold_valid;
    assign tx_busy  = (r_state != c_IDLE) || r_hold_valid || w_brk_busy;

    // A write coinciding with a transfer refills the slot being emptied.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (wr_en && (!r_hold_valid || w_load)) begin
                r_hold       <= din;
                r_hold_valid <= 1'b1;
            end else begin
                if (w_load) r_hold_valid <= 1'b0;
                if (wr_en)  r_overrun    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= 4'd0;
            r_stopcnt <= 1'b0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
`ifdef UART_TX_BREAK_EN
            r_brk_on    <= 1'b0;
            r_brk_guard <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        r_tx     <= 1'b0;
                        r_brk_on <= 1'b1;
                    end else if (r_brk_on) begin
                        r_tx        <= 1'b1;
                        r_brk_on    <= 1'b0;
                        r_brk_guard <= 1'b1;
                    end else if (clken) begin
                        r_brk_guard <= 1'b0;
                    end
`endif
                    if (w_load) begin
                        r_shift  <= r_hold;
                        r_parity <= (^r_hold) ^ c_ODD;
                        r_tx     <= 1'b0;
                        r_state  <= c_START;
                    end
                end
                c_START: if (clken) begin
                    r_tx     <= r_shift[0];
                    r_shift  <= r_shift >> 1;
                    r_bitcnt <= 4'd1;
                    r_state  <= c_DATA;
                end
                c_DATA: if (clken) begin
                    if (r_bitcnt < c_DATA_BITS) begin
                        r_tx     <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (PARITY != 0) begin
                        r_tx    <= r_parity;
                        r_state <= c_PARITY;
                    end else begin
                        r_tx      <= 1'b1;
                        r_stopcnt <= 1'b0;
                        r_state   <= c_STOP;
                    end
                end
                c_PARITY: if (clken) begin
                    r_tx      <= 1'b1;
                    r_stopcnt <= 1'b0;
                    r_state   <= c_STOP;
                end
                c_STOP: if (clken) begin
                    if (!w_stop_done) begin
                        r_stopcnt <= r_stopcnt + 1'b1;
                    end else if (w_load) begin
                        r_shift  <= r_hold;
                        r_parity <= (^r_hold) ^ c_ODD;
                        r_tx     <= 1'b0;
                        r_state  <= c_START;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame: three configurations, frame
//            scoreboard sampled once per bit period, plus corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_n;
    logic       ce4;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [4:0] din2;
    logic [2:0] wr;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] rdy_v;
    logic [2:0] ovr_v;
`ifdef UART_TX_BREAK_EN
    logic       brk;
    logic       brk_off;
`endif

    int  total = 0;
    int  bad   = 0;
    bit  ce_q;
    bit  q [3][$];
    bit  infr [3];
    bit  mon_en [3];
    int  period [3];
    int  nbit [3];
    int  last_start [3];
    int  prev_start [3];
    int  flen [3] = '{11, 11, 7};
    int  cdiv = 0;

    typedef struct {
        int          dut;
        logic [8:0]  din;
        logic [15:0] frame;
        int          len;
    } vec_t;
    vec_t tbl [8];

    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u0 (
        .clk_50m(clk), .rst_n(rst_n), .din(din0), .wr_en(wr[0]), .clken(ce4),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_ready(rdy_v[0]), .overrun(ovr_v[0]));

    uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk_50m(clk), .rst_n(rst_n), .din(din1), .wr_en(wr[1]), .clken(ce4),
`ifdef UART_TX_BREAK_EN
        .brk(brk_off),
`endif
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_ready(rdy_v[1]), .overrun(ovr_v[1]));

    uart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u2 (
        .clk_50m(clk), .rst_n(rst_n), .din(din2), .wr_en(wr[2]), .clken(1'b1),
`ifdef UART_TX_BREAK_EN
        .brk(brk_off),
`endif
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_ready(rdy_v[2]), .overrun(ovr_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ce4 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cdiv = (cdiv + 1) % 4;
            ce4  = (cdiv == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mkframe(input int dbits, input int par, input int stops,
                                            input logic [8:0] w, output int len);
        logic [15:0] f;
        logic        p;
        f   = '0;
        p   = 1'b0;
        len = 1;
        for (int i = 0; i < dbits; i++) begin
            f = {f[14:0], w[i]};
            p = p ^ w[i];
            len++;
        end
        if (par != 0) begin
            f = {f[14:0], (par == 2) ? ~p : p};
            len++;
        end
        for (int i = 0; i < stops; i++) begin
            f = {f[14:0], 1'b1};
            len++;
        end
        return f;
    endfunction

    task automatic push(input int d, input logic [15:0] f, input int len);
        for (int i = len - 1; i >= 0; i--) q[d].push_back(f[i]);
    endtask

    // One monitor call per bit period: first low bit with pending data opens a frame.
    task automatic mon(input int d);
        bit e;
        period[d]++;
        if (!mon_en[d]) return;
        if (infr[d] || (q[d].size() != 0 && tx_v[d] == 1'b0)) begin
            e = (q[d].size() != 0) ? q[d].pop_front() : 1'b1;
            if (!infr[d]) begin
                infr[d]       = 1'b1;
                nbit[d]       = 0;
                prev_start[d] = last_start[d];
                last_start[d] = period[d];
            end
            chk($sformatf("tx_bit%0d", d), tx_v[d], e);
            chk($sformatf("busy_in_frame%0d", d), busy_v[d], 1);
            nbit[d]++;
            if (nbit[d] == flen[d]) infr[d] = 1'b0;
        end else begin
            chk($sformatf("tx_idle%0d", d), tx_v[d], 1);
        end
    endtask

    always @(posedge clk) ce_q = ce4;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ce_q) begin
                mon(0);
                mon(1);
            end
            mon(2);
        end
    end

    task automatic do_write(input int d, input logic [8:0] w);
        @(posedge clk);
        #1;
        case (d)
            0:       din0 = w[7:0];
            1:       din1 = w[6:0];
            default: din2 = w[4:0];
        endcase
        wr[d] = 1'b1;
        @(posedge clk);
        #1;
        wr[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((q[d].size() != 0 || infr[d] || busy_v[d]) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk($sformatf("drain_timeout%0d", d), 1, 0);
        chk($sformatf("busy_after%0d", d), busy_v[d], 0);
        chk($sformatf("ready_after%0d", d), rdy_v[d], 1);
    endtask

    task automatic b2b(input int d, input logic [8:0] w1, input logic [8:0] w2,
                       input int dbits, input int par, input int stops, input bit ovr);
        int len;
        int n;
        logic [15:0] f;
        f = mkframe(dbits, par, stops, w1, len);
        push(d, f, len);
        do_write(d, w1);
        chk("ready_drop", rdy_v[d], 0);
        n = 0;
        while (!rdy_v[d] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("ready_timeout", 1, 0);
        f = mkframe(dbits, par, stops, w2, len);
        push(d, f, len);
        do_write(d, w2);
        chk("overrun_quiet", ovr_v[d], 0);
        if (ovr) begin
            do_write(d, 9'h1C3);
            chk("overrun_pulse", ovr_v[d], 1);
            @(posedge clk);
            #1;
            chk("overrun_single", ovr_v[d], 0);
        end
        drain(d);
        chk("b2b_gap", last_start[d] - prev_start[d], flen[d]);
    endtask

    initial begin
        int len;
        int n;
        int rise_p;
        logic [15:0] f;

        tbl[0] = '{0, 9'h0A5, 16'b01010010101, 11};
        tbl[1] = '{0, 9'h000, 16'b00000000001, 11};
        tbl[2] = '{0, 9'h0FF, 16'b01111111101, 11};
        tbl[3] = '{0, 9'h001, 16'b01000000011, 11};
        tbl[4] = '{1, 9'h041, 16'b01000001111, 11};
        tbl[5] = '{1, 9'h07F, 16'b01111111011, 11};
        tbl[6] = '{2, 9'h013, 16'b0110011, 7};
        tbl[7] = '{2, 9'h00A, 16'b0010101, 7};

        rst_n = 1'b0;
        wr    = '0;
        din0  = '0;
        din1  = '0;
        din2  = '0;
`ifdef UART_TX_BREAK_EN
        brk     = 1'b0;
        brk_off = 1'b0;
`endif
        for (int d = 0; d < 3; d++) begin
            mon_en[d] = 1'b1;
            infr[d]   = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_tx", tx_v[d], 1);
            chk("rst_busy", busy_v[d], 0);
            chk("rst_ready", rdy_v[d], 1);
            chk("rst_overrun", ovr_v[d], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            push(tbl[i].dut, tbl[i].frame, tbl[i].len);
            do_write(tbl[i].dut, tbl[i].din);
            drain(tbl[i].dut);
        end

        b2b(0, 9'h055, 9'h0AA, 8, 1, 1, 1'b1);
        b2b(1, 9'h041, 9'h07F, 7, 2, 2, 1'b0);

        // Reset while data bit 3 of 0xFF is on the line.
        f = mkframe(8, 1, 1, 9'h0FF, len);
        push(0, f, len);
        do_write(0, 9'h0FF);
        n = 0;
        while (!(infr[0] && nbit[0] == 5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("midframe_timeout", 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx_v[0], 1);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_ready", rdy_v[0], 1);
        for (int d = 0; d < 3; d++) begin
            q[d].delete();
            infr[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_busy", busy_v[0], 0);
        chk("postrst_ready", rdy_v[0], 1);
        push(0, f, len);
        do_write(0, 9'h0FF);
        drain(0);

`ifdef UART_TX_BREAK_EN
        mon_en[0] = 1'b0;
        f = mkframe(8, 1, 1, 9'h03C, len);
        push(0, f, len);
        @(posedge clk);
        #1;
        brk = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) begin
                din0  = 8'h3C;
                wr[0] = 1'b1;
            end else begin
                wr[0] = 1'b0;
            end
            chk("brk_low", tx_v[0], 0);
            chk("brk_busy", busy_v[0], 1);
        end
        brk = 1'b0;
        @(posedge clk);
        #1;
        chk("brk_release", tx_v[0], 1);
        rise_p    = period[0];
        mon_en[0] = 1'b1;
        drain(0);
        chk("brk_idle_gap", (last_start[0] - rise_p) >= 2, 1);
`else
        rise_p = 0;
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises one word per frame with configurable data width, parity and stop-bit count.
- Bit timing comes from an external baud enable (clken) from the existing baud generator.
- A one-word holding register lets the host queue the next word while a frame is shifting, so frames go out back-to-back with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9; LSB transmitted first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk_50m  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_BITS  word to transmit; sampled when wr_en=1 is accepted.
- wr_en  input  1  write strobe, one clk_50m cycle per word.
- clken  input  1  baud enable, one-cycle pulse per bit period.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high while a frame is in progress or a word is pending.
- tx_ready  output  1  high when the holding register is empty.
- overrun  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Clocking and reset:
  - One clock (clk_50m); reset is asynchronous and active-low (rst_n).
  - Reset, including mid-frame: tx=1, overrun=0, state=IDLE, holding register cleared (tx_ready=1, tx_busy=0), bit and stop counters=0.
  - A partial frame is abandoned with no glitch low.
- Holding register:
  - wr_en with hold empty captures din and sets hold_valid next cycle.
  - A transfer to the shift register (IDLE->START or STOP->START) clears hold_valid.
  - wr_en in the same cycle as a transfer is accepted: the new word lands and hold_valid stays 1.
  - wr_en with hold full and no transfer that cycle: din is dropped and overrun=1 for exactly one cycle.
- Outputs: tx_ready = !hold_valid; tx_busy = (state!=IDLE) | hold_valid, both combinational from registers.
- State machine: IDLE, START, DATA, PARITY, STOP. Every transition and every tx update happens only on cycles with clken=1.
  - IDLE: tx=1. On clken with hold_valid: load shift register, tx<=0, go to START. A word written between clken pulses waits for the next clken, so the start bit is always aligned to clken.
  - START: on clken, tx<=data[0], bitcnt<=1, go to DATA.
  - DATA: on clken:
    - if bitcnt<DATA_BITS: tx<=data[bitcnt], bitcnt++;
    - else if PARITY!=0: tx<=parity bit, go to PARITY;
    - else: tx<=1, stopcnt<=0, go to STOP.
  - PARITY: on clken, tx<=1, stopcnt<=0, go to STOP.
  - STOP: on clken:
    - if stopcnt<STOP_BITS-1: stopcnt++ (tx stays 1);
    - else if hold_valid: load next word, tx<=0, go to START (back-to-back);
    - else go to IDLE.
- Parity: even = XOR of all DATA_BITS data bits; odd = its inverse. Computed from the word latched into the shift register, so din changes mid-frame have no effect.
- Frame length is exactly 1 + DATA_BITS + (PARITY!=0) + STOP_BITS clken periods. Each bit level holds from one clken edge to the next.
- clken asserted continuously gives one bit per clk_50m cycle; this must work.
- Illegal parameter values are flagged by a simulation-time $error at elaboration.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined, adds input port brk (1 bit), placed after clken:
  - brk=1 while in IDLE: tx<=0 on the next clk_50m edge and is held low while brk=1; tx_busy=1.
  - brk=1 during a frame has no effect until the frame ends in IDLE.
  - On brk deassert: tx<=1 immediately, then at least one full clken period of idle before any pending word starts.
  - Pending words are kept, not dropped.
- When undefined: no brk port; tx low only during start/data/parity bits.

Test Plan:
- DATA_BITS=8, PARITY=1, STOP_BITS=1, clken every 4 clocks, write 0xA5 -> tx per clken: 0,1,0,1,0,0,1,0,1,0(parity),1(stop); tx_busy high for 11 bit periods, then low.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x41 -> 0,1,0,0,0,0,0,1,1(odd parity),1,1; next start no earlier than 11 periods after the first start.
- Write 0x55 then 0xAA one cycle apart -> tx_ready drops and returns after the first transfer; second frame's start bit follows first frame's stop bit with no idle period; a third write while hold full -> overrun single-cycle pulse, that word never appears on tx.
- Assert rst_n low during data bit 3 of 0xFF -> tx=1 the same instant, tx_busy=0 and tx_ready=1 after release; next write sends a complete clean frame.
- clken tied high, DATA_BITS=5, PARITY=0, write 0x13 -> frame 0,1,1,0,0,1,1 on consecutive clk_50m cycles.
- UART_TX_BREAK_EN defined: brk high 20 clocks in IDLE with 0x3C written mid-break -> tx low for 20 clocks, high for at least one clken period, then the 0x3C frame.
